// File: rtl/p2s_lane_serializer.sv
// Parallel-to-serial lane converter: splits an N-bit word into N/W beats of W bits,
// with valid/ready on both sides and an optional one-word holding buffer.
module p2s_lane_serializer #(
  parameter int N         = 8,
  parameter int W         = 1,
  parameter int MSB_FIRST = 1,
  parameter int BUFFERED  = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] par_data,
  input  logic         par_valid,
  output logic         par_ready,
  output logic [W-1:0] ser_data,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         ser_last
);

  localparam int BEATS = N / W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  generate
    if ((W < 1) || (N < W) || ((N % W) != 0)) begin : g_bad_params
      $error("p2s_lane_serializer: N must be a positive multiple of W");
    end
  endgenerate

  // Handshake rule (both sides): a transfer happens on a rising edge where valid and
  // ready are both high; the sender keeps data stable while valid is high and ready low.

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state;
  logic [N-1:0]  sreg;
  logic [N-1:0]  sreg_shifted;
  logic [N-1:0]  hold;
  logic          hold_v;
  logic [CW-1:0] cnt;
  logic          run;
  logic          beat_last;
  logic          p_fire;
  logic          s_fire;

  assign ser_valid = (state == SHIFT);
  assign beat_last = (cnt == LAST_CNT);
  assign ser_last  = ser_valid & beat_last;
  assign p_fire    = par_valid & par_ready;
  assign s_fire    = ser_valid & ser_ready;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign ser_data     = sreg[N-1 -: W];
      assign sreg_shifted = sreg << W;
    end else begin : g_lsb
      assign ser_data     = sreg[W-1:0];
      assign sreg_shifted = sreg >> W;
    end
  endgenerate

  // run holds par_ready low through reset and rises on the first edge after release.
  generate
    if (BUFFERED != 0) begin : g_ready_buf
      assign par_ready = run & ~hold_v;
    end else begin : g_ready_direct
      assign par_ready = run & (~ser_valid | (ser_ready & ser_last));
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      sreg   <= '0;
      hold   <= '0;
      hold_v <= 1'b0;
      cnt    <= '0;
      run    <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        IDLE: begin
          if (p_fire) begin
            sreg  <= par_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (s_fire && beat_last) begin
            cnt <= '0;
            // Next word priority: held word, then same-cycle bypass, else go idle.
            if ((BUFFERED != 0) && hold_v) begin
              sreg <= hold;
              if (p_fire) begin
                hold <= par_data;
              end else begin
                hold_v <= 1'b0;
              end
            end else if (p_fire) begin
              sreg <= par_data;
            end else begin
              sreg  <= sreg_shifted;
              state <= IDLE;
            end
          end else begin
            if (s_fire) begin
              sreg <= sreg_shifted;
              cnt  <= cnt + CW'(1);
            end
            if ((BUFFERED != 0) && p_fire) begin
              hold   <= par_data;
              hold_v <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_lane_serializer.sv
// Bench for p2s_lane_serializer: four configurations, directed vectors, hand-written
// corner sequences and a randomized run against a word-level beat-queue model.
module tb_p2s_lane_serializer;

  logic       clk = 1'b0;
  logic       rstn;
  int         sel;
  logic       pv_c;
  logic       sr_c;
  logic [7:0] pd_c;

  logic pv0, pv1, pv2, pv3;
  logic sr0, sr1, sr2, sr3;
  logic pr0, pr1, pr2, pr3;
  logic sv0, sv1, sv2, sv3;
  logic sl0, sl1, sl2, sl3;
  logic [0:0] sd0;
  logic [0:0] sd1;
  logic [1:0] sd2;
  logic [3:0] sd3;

  logic       o_pr, o_sv, o_sl;
  logic [3:0] o_sd;

  int checks = 0;
  int errors = 0;

  // Per-instance configuration mirrored from the instance parameters below.
  int cfg_n[4]   = '{4, 4, 8, 4};
  int cfg_w[4]   = '{1, 1, 2, 4};
  int cfg_msb[4] = '{1, 0, 1, 1};
  int cfg_buf[4] = '{1, 0, 1, 0};

  logic [4:0] exp_q[$];

  typedef struct {
    int         sel;
    logic [7:0] word;
    int         nb;
    logic [15:0] beats;
  } vec_t;

  vec_t vecs[6];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign pv0 = pv_c && (sel == 0);
  assign pv1 = pv_c && (sel == 1);
  assign pv2 = pv_c && (sel == 2);
  assign pv3 = pv_c && (sel == 3);
  assign sr0 = sr_c && (sel == 0);
  assign sr1 = sr_c && (sel == 1);
  assign sr2 = sr_c && (sel == 2);
  assign sr3 = sr_c && (sel == 3);

  p2s_lane_serializer #(.N(4), .W(1), .MSB_FIRST(1), .BUFFERED(1)) u_a (
    .clk(clk), .rstn(rstn), .par_data(pd_c[3:0]), .par_valid(pv0), .par_ready(pr0),
    .ser_data(sd0), .ser_valid(sv0), .ser_ready(sr0), .ser_last(sl0));

  p2s_lane_serializer #(.N(4), .W(1), .MSB_FIRST(0), .BUFFERED(0)) u_b (
    .clk(clk), .rstn(rstn), .par_data(pd_c[3:0]), .par_valid(pv1), .par_ready(pr1),
    .ser_data(sd1), .ser_valid(sv1), .ser_ready(sr1), .ser_last(sl1));

  p2s_lane_serializer #(.N(8), .W(2), .MSB_FIRST(1), .BUFFERED(1)) u_c (
    .clk(clk), .rstn(rstn), .par_data(pd_c), .par_valid(pv2), .par_ready(pr2),
    .ser_data(sd2), .ser_valid(sv2), .ser_ready(sr2), .ser_last(sl2));

  p2s_lane_serializer #(.N(4), .W(4), .MSB_FIRST(1), .BUFFERED(0)) u_d (
    .clk(clk), .rstn(rstn), .par_data(pd_c[3:0]), .par_valid(pv3), .par_ready(pr3),
    .ser_data(sd3), .ser_valid(sv3), .ser_ready(sr3), .ser_last(sl3));

  always_comb begin
    o_pr = 1'b0;
    o_sv = 1'b0;
    o_sl = 1'b0;
    o_sd = '0;
    case (sel)
      0: begin o_pr = pr0; o_sv = sv0; o_sl = sl0; o_sd = {3'b000, sd0}; end
      1: begin o_pr = pr1; o_sv = sv1; o_sl = sl1; o_sd = {3'b000, sd1}; end
      2: begin o_pr = pr2; o_sv = sv2; o_sl = sl2; o_sd = {2'b00, sd2}; end
      default: begin o_pr = pr3; o_sv = sv3; o_sl = sl3; o_sd = sd3; end
    endcase
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_beat(input string name, input logic [3:0] d, input logic l);
    chk({name, "_valid"}, o_sv, 1'b1);
    chk({name, "_data"}, o_sd, d);
    chk({name, "_last"}, o_sl, l);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_valid"}, o_sv, 1'b0);
    chk({name, "_last"}, o_sl, 1'b0);
  endtask

  // Beat b of a word, straight from the slicing rule: MSB-first counts down from the top.
  function automatic logic [3:0] beat_of(input int s, input logic [7:0] word, input int b);
    int sh;
    logic [7:0] m;
    sh = (cfg_msb[s] != 0) ? cfg_n[s] - cfg_w[s] * (b + 1) : cfg_w[s] * b;
    m  = (8'd1 << cfg_w[s]) - 8'd1;
    return 4'((word >> sh) & m);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_vec(input int i);
    string nm;
    sel = vecs[i].sel;
    @(negedge clk);
    pd_c = vecs[i].word; pv_c = 1'b1; sr_c = 1'b1;
    #1 chk($sformatf("vec%0d_ready", i), o_pr, 1'b1);
    for (int b = 0; b < vecs[i].nb; b++) begin
      @(negedge clk);
      pv_c = 1'b0;
      nm = $sformatf("vec%0d_b%0d", i, b);
      #1 chk_beat(nm, vecs[i].beats[15 - 4*b -: 4], b == vecs[i].nb - 1);
    end
    @(negedge clk);
    #1 chk_idle($sformatf("vec%0d_end", i));
    sr_c = 1'b0;
  endtask

  task automatic run_random(input int s, input int cycles);
    logic pend = 1'b0;
    logic m_sv, m_pr, m_sl, p_m, s_m;
    logic [3:0] m_sd;
    logic [4:0] head;
    int inflight = 0;
    int nb;
    bit done = 1'b0;
    sel = s;
    nb = cfg_n[s] / cfg_w[s];
    exp_q.delete();
    for (int c = 0; (c < cycles + 100) && !done; c++) begin
      @(negedge clk);
      if (c < cycles) begin
        if (!pend) begin
          pv_c = ($urandom_range(0, 99) < 55);
          pd_c = 8'($urandom);
        end
        sr_c = ($urandom_range(0, 99) < 70);
      end else begin
        pv_c = pend;
        sr_c = 1'b1;
      end
      #1;
      m_sv = (exp_q.size() > 0);
      head = m_sv ? exp_q[0] : 5'd0;
      m_sl = head[4];
      m_sd = head[3:0];
      m_pr = (cfg_buf[s] != 0) ? (inflight < 2) : ((inflight == 0) || (sr_c && m_sl));
      chk($sformatf("rnd%0d_valid", s), o_sv, m_sv);
      chk($sformatf("rnd%0d_ready", s), o_pr, m_pr);
      chk($sformatf("rnd%0d_last", s), o_sl, m_sl);
      if (m_sv) chk($sformatf("rnd%0d_data", s), o_sd, m_sd);
      p_m = pv_c && m_pr;
      s_m = m_sv && sr_c;
      if (s_m) begin
        void'(exp_q.pop_front());
        if (head[4]) inflight--;
      end
      if (p_m) begin
        for (int b = 0; b < nb; b++) exp_q.push_back({(b == nb - 1), beat_of(s, pd_c, b)});
        inflight++;
      end
      pend = pv_c && !p_m;
      if ((c >= cycles) && !pend && (exp_q.size() == 0)) done = 1'b1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rnd%0d_drain: %0d beats outstanding, expected 0", s, exp_q.size());
    end
    pv_c = 1'b0;
    sr_c = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{0, 8'h0B, 4, 16'h1011};  // MSB-first 1011 -> 1,0,1,1
    vecs[1] = '{1, 8'h0B, 4, 16'h1101};  // LSB-first 1011 -> 1,1,0,1
    vecs[2] = '{2, 8'hB4, 4, 16'h2310};  // 8'hB4 in 2-bit beats -> 10,11,01,00
    vecs[3] = '{2, 8'h1E, 4, 16'h0132};
    vecs[4] = '{1, 8'h01, 4, 16'h1000};
    vecs[5] = '{3, 8'h0A, 1, 16'hA000};  // single-beat word

    rstn = 1'b0; pv_c = 1'b0; sr_c = 1'b0; pd_c = '0; sel = 0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      chk($sformatf("rst%0d_valid", s), o_sv, 1'b0);
      chk($sformatf("rst%0d_ready", s), o_pr, 1'b0);
      chk($sformatf("rst%0d_last", s), o_sl, 1'b0);
      chk($sformatf("rst%0d_data", s), o_sd, 4'h0);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1 chk($sformatf("rel%0d_ready", s), o_pr, 1'b1);
    end

    for (int i = 0; i < 6; i++) apply_vec(i);

    // Back-to-back words through the holding register: 8 contiguous beats.
    sel = 0;
    @(negedge clk);
    pd_c = 8'h0D; pv_c = 1'b1; sr_c = 1'b1;
    #1 chk("b2b_ready0", o_pr, 1'b1);
    @(negedge clk);
    pd_c = 8'h06;
    #1 chk_beat("b2b_b0", 4'h1, 1'b0);
    chk("b2b_ready1", o_pr, 1'b1);
    for (int i = 1; i < 8; i++) begin
      logic [7:0] stream;
      stream = 8'hD6;
      @(negedge clk);
      pv_c = 1'b0;
      #1 chk_beat($sformatf("b2b_b%0d", i), {3'b000, stream[7 - i]}, (i == 3) || (i == 7));
      chk($sformatf("b2b_ready_b%0d", i), o_pr, (i >= 4));
    end
    @(negedge clk);
    #1 chk_idle("b2b_end");

    // Backpressure on the second beat of 1011.
    @(negedge clk);
    pd_c = 8'h0B; pv_c = 1'b1; sr_c = 1'b1;
    @(negedge clk);
    pv_c = 1'b0;
    #1 chk_beat("bp_b0", 4'h1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sr_c = 1'b0;
      #1 chk_beat($sformatf("bp_stall%0d", i), 4'h0, 1'b0);
    end
    @(negedge clk);
    sr_c = 1'b1;
    #1 chk_beat("bp_b1", 4'h0, 1'b0);
    @(negedge clk);
    #1 chk_beat("bp_b2", 4'h1, 1'b0);
    @(negedge clk);
    #1 chk_beat("bp_b3", 4'h1, 1'b1);
    @(negedge clk);
    #1 chk_idle("bp_end");

    // Reset mid-word with a word waiting in the holding register.
    @(negedge clk);
    pd_c = 8'h0B; pv_c = 1'b1; sr_c = 1'b1;
    @(negedge clk);
    pd_c = 8'h09;
    @(negedge clk);
    pv_c = 1'b0;
    #1 chk_beat("mr_b1", 4'h0, 1'b0);
    chk("mr_hold_ready", o_pr, 1'b0);
    rstn = 1'b0;
    #1;
    chk("mr_rst_valid", o_sv, 1'b0);
    chk("mr_rst_ready", o_pr, 1'b0);
    chk("mr_rst_last", o_sl, 1'b0);
    chk("mr_rst_data", o_sd, 4'h0);
    @(negedge clk);
    #1 chk("mr_rst2_ready", o_pr, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1 chk("mr_rel_ready", o_pr, 1'b1);
    chk_idle("mr_rel");
    @(negedge clk);
    pd_c = 8'h06; pv_c = 1'b1;
    for (int b = 0; b < 4; b++) begin
      logic [3:0] w6;
      w6 = 4'b0110;
      @(negedge clk);
      pv_c = 1'b0;
      #1 chk_beat($sformatf("mr_new_b%0d", b), {3'b000, w6[3 - b]}, b == 3);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 chk_idle($sformatf("mr_tail%0d", i));
    end
    sr_c = 1'b0;

    for (int s = 0; s < 4; s++) run_random(s, 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
